formula_loader: RTL and testbench
=================================

# formula_loader

Streaming front end for the SAT solver core. It accepts a CNF formula one literal per cycle over a valid/ready handshake and assembles it into the packed `formula` structure from `common`. It then presents the complete formula to the solver over a second valid/ready handshake. It is the producer side of the `formula` interface that the solver core and formula stack consume.

## Interface
Parameters come from `common`; the block has no local parameters.
- `number_literal`, 5: maximum literals per clause, and highest legal literal number.
- `number_clauses`, 10: maximum clauses per formula.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert and active-low.
- `lit_valid`  in  1  input beat valid.
- `lit_ready`  out  1  loader can accept a beat.
- `lit_num`  in  width_litarray+1 (3)  variable number; legal range 1..number_literal.
- `lit_val`  in  1  literal polarity; 1 = positive.
- `lit_last`  in  1  beat is the last literal of its clause.
- `frm_last`  in  1  beat is the last literal of the formula; implies `lit_last`.
- `formula_o`  out  $bits(formula)  assembled formula.
- `formula_valid`  out  1  `formula_o` is complete and stable.
- `formula_ready`  in  1  consumer accepts `formula_o`.
- `err`  out  1  the formula being presented is invalid; qualified by `formula_valid`.

## Operation
The block has three states: COLLECT, DRAIN and DONE.

COLLECT:
- `lit_ready`=1. A beat is accepted when `lit_valid && lit_ready`.
- On an accepted beat, write `{num:lit_num, val:lit_val}` to `clauses[c_idx].lits[l_idx]`, then increment `l_idx`.
- `lit_last`: set `clauses[c_idx].len` = `l_idx+1`, increment `c_idx`, clear `l_idx`.
- `frm_last`: finish the current clause as for `lit_last`, even if `lit_last`=0. Set `formula.len` = `c_idx+1` and go to DONE.
- Error conditions on an accepted beat:
  - `lit_num`==0;
  - `lit_num`>number_literal;
  - `l_idx`==number_literal, i.e. a sixth literal arrives for one clause;
  - `c_idx`==number_clauses, i.e. an eleventh clause is started.
- On an error, set `err`, do not write the beat, and go to DRAIN. If the erroring beat also has `frm_last`, go straight to DONE.

DRAIN:
- `lit_ready`=1. Accepted beats are discarded.
- An accepted beat with `frm_last` goes to DONE.

DONE:
- `formula_valid`=1 and `lit_ready`=0.
- `formula_o` and `err` are held constant.
- If `err`=1, `formula_o.len` is forced to 0 and the clause contents are don't-care.
- On `formula_valid && formula_ready`, go to COLLECT. In the same edge, clear storage to `zero_formula` and clear `c_idx`, `l_idx` and `err`.

Other rules:
- Unwritten clause and literal slots stay zero.
- Counter widths: `l_idx` is width_litarray+1 bits and `c_idx` is width_clausearray+1 bits. Both saturate checks are done before increment, so neither counter wraps.

## Timing
- Reset values while `rst_n`=0: `lit_ready`=0, `formula_valid`=0, `err`=0, `formula_o`=`zero_formula`. State is COLLECT and counters are 0.
- `lit_ready` rises on the first edge after `rst_n` deasserts.
- Reset mid-formula discards all partial contents immediately, because reset is asynchronous.
- Throughput is one literal per cycle with no bubbles within a formula.
- Latency: a `frm_last` beat accepted at edge N gives `formula_valid`=1 from edge N, visible in cycle N+1.
- Handoff: a `formula_ready` handshake at edge M gives `lit_ready`=1 in cycle M+1. Between formulas there is a minimum one-cycle gap with no input accepted.
- Input signals are don't-care when `lit_valid`=0.
- `formula_valid`, once high, stays high until the handshake completes.
- `formula_ready` held high while in COLLECT has no effect.

## Structure
- Additions to `common`:
  - `lit_beat` struct: `{num, val, lit_last, frm_last}`.
  - `loader_state_t` enum: COLLECT, DRAIN, DONE.
  - Index widths reuse `width_litarray` and `width_clausearray`.
  - `zero_formula` is the clear value.
- One sub-module is natural: `clause_builder`. It owns `l_idx` and one clause register, flags overflow and illegal literal numbers, and emits a completed clause plus `done`. The top level holds `c_idx`, the clause array, the FSM and the output handshake.

## Test plan
- Single-clause formula: beats (1,+), (3,−), then (5,+) with `lit_last`=`frm_last`=1 → `formula_valid` asserts the next cycle. Expect `len`=1, `clauses[0].len`=3, lits `{1,1}{3,0}{5,1}`, other slots zero, `err`=0.
- Full capacity: 10 clauses of 5 literals each → `len`=10, every clause `len`=5. `lit_ready` is high on all 50 beats.
- Clause overflow: 6 literals without `lit_last`, then 2 more beats, the last with `frm_last` → DRAIN after beat 6. Expect `err`=1 and `formula_o.len`=0.
- Illegal literal: `lit_num`=0 mid-clause, then further beats until `frm_last` → `err`=1.
- Backpressure: hold `formula_ready`=0 for 4 cycles after valid → `formula_o` is stable and `lit_ready`=0 throughout. After the handshake, a second formula loads correctly with no residue from the first.
- Reset mid-formula: assert `rst_n`=0 after 3 beats → outputs go to reset values immediately. After release, a fresh 2-clause formula yields `len`=2.

Source files
------------

// File: rtl/formula_loader_pkg.sv
// Shared types and sizing for the CNF formula loader and its consumers.
package formula_loader_pkg;
  localparam int number_literal    = 5;
  localparam int number_clauses    = 10;
  localparam int width_litarray    = $clog2(number_literal) - 1;
  localparam int width_clausearray = $clog2(number_clauses) - 1;

  localparam logic [width_litarray:0]    max_lits    = number_literal[width_litarray:0];
  localparam logic [width_clausearray:0] max_clauses = number_clauses[width_clausearray:0];

  typedef struct packed {
    logic [width_litarray:0] num;
    logic                    val;
  } literal_t;

  typedef struct packed {
    literal_t [number_literal-1:0] lits;
    logic [width_litarray:0]       len;
  } clause_t;

  typedef struct packed {
    clause_t [number_clauses-1:0] clauses;
    logic [width_clausearray:0]   len;
  } formula_t;

  typedef struct packed {
    logic [width_litarray:0] num;
    logic                    val;
    logic                    lit_last;
    logic                    frm_last;
  } lit_beat;

  typedef enum logic [1:0] {COLLECT, DRAIN, DONE} loader_state_t;

  localparam formula_t zero_formula = '0;

  function automatic logic legal_num(input logic [width_litarray:0] n);
    return (n != '0) && (n <= max_lits);
  endfunction
endpackage

// File: rtl/formula_loader_if.sv
// Literal stream in, assembled formula out; master drives literals and consumes the formula.
interface formula_loader_if;
  import formula_loader_pkg::*;

  logic                    lit_valid;
  logic                    lit_ready;
  logic [width_litarray:0] lit_num;
  logic                    lit_val;
  logic                    lit_last;
  logic                    frm_last;
  formula_t                formula_o;
  logic                    formula_valid;
  logic                    formula_ready;
  logic                    err;

  modport master (
    output lit_valid, lit_num, lit_val, lit_last, frm_last, formula_ready,
    input  lit_ready, formula_o, formula_valid, err
  );

  modport slave (
    input  lit_valid, lit_num, lit_val, lit_last, frm_last, formula_ready,
    output lit_ready, formula_o, formula_valid, err
  );
endinterface

// File: rtl/formula_loader_clause_builder.sv
// Accumulates literals of the clause in progress and flags per-clause errors.
module formula_loader_clause_builder
  import formula_loader_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  lit_beat beat,
  input  logic    take,
  input  logic    hold,
  input  logic    clear,
  output clause_t clause_o,
  output logic    done,
  output logic    bad
);
  clause_t                 cur;
  logic [width_litarray:0] l_idx;
  logic                    wr;
  logic                    end_c;

  assign end_c = beat.lit_last | beat.frm_last;
  assign bad   = take && (!legal_num(beat.num) || (l_idx == max_lits));
  assign wr    = take && !bad && !hold;
  assign done  = wr && end_c;

  // clause_o is the clause with the current beat appended, ready to store on done
  always_comb begin
    clause_o = cur;
    if (l_idx < max_lits) begin
      clause_o.lits[l_idx] = '{num: beat.num, val: beat.val};
    end
    clause_o.len = l_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur   <= '0;
      l_idx <= '0;
    end else if (clear) begin
      cur   <= '0;
      l_idx <= '0;
    end else if (wr) begin
      if (end_c) begin
        cur   <= '0;
        l_idx <= '0;
      end else begin
        cur   <= clause_o;
        l_idx <= l_idx + 1'b1;
      end
    end
  end
endmodule

// File: rtl/formula_loader.sv
// Streams CNF literals into a packed formula and hands it to the solver via valid/ready.
module formula_loader
  import formula_loader_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  formula_loader_if.slave bus
);
  loader_state_t              state;
  formula_t                   frm;
  logic [width_clausearray:0] c_idx;
  logic                       lit_ready_q;
  logic                       valid_q;
  logic                       err_q;
  lit_beat                    beat;
  clause_t                    clause_done;
  logic                       accept, take, c_full, bad_lit, clause_end, beat_err, handoff;

  assign beat     = '{num: bus.lit_num, val: bus.lit_val,
                      lit_last: bus.lit_last, frm_last: bus.frm_last};
  assign accept   = bus.lit_valid && lit_ready_q;
  assign take     = accept && (state == COLLECT);
  assign c_full   = (c_idx == max_clauses);
  assign beat_err = bad_lit || (take && c_full);
  assign handoff  = (state == DONE) && bus.formula_ready;

  formula_loader_clause_builder u_builder (
    .clk      (clk),
    .rst_n    (rst_n),
    .beat     (beat),
    .take     (take),
    .hold     (c_full),
    .clear    (handoff),
    .clause_o (clause_done),
    .done     (clause_end),
    .bad      (bad_lit)
  );

  // formula len is only written on an error-free finish, so an invalid formula presents len 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= COLLECT;
      lit_ready_q <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      frm         <= zero_formula;
      c_idx       <= '0;
    end else begin
      unique case (state)
        COLLECT: begin
          lit_ready_q <= 1'b1;
          if (take) begin
            if (beat_err) err_q <= 1'b1;
            if (clause_end) begin
              frm.clauses[c_idx] <= clause_done;
              c_idx              <= c_idx + 1'b1;
            end
            if (beat.frm_last) begin
              if (!beat_err) frm.len <= c_idx + 1'b1;
              state       <= DONE;
              lit_ready_q <= 1'b0;
              valid_q     <= 1'b1;
            end else if (beat_err) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          lit_ready_q <= 1'b1;
          if (accept && beat.frm_last) begin
            state       <= DONE;
            lit_ready_q <= 1'b0;
            valid_q     <= 1'b1;
          end
        end
        DONE: begin
          if (handoff) begin
            state       <= COLLECT;
            lit_ready_q <= 1'b1;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            frm         <= zero_formula;
            c_idx       <= '0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign bus.lit_ready     = lit_ready_q;
  assign bus.formula_valid = valid_q;
  assign bus.err           = err_q;
  assign bus.formula_o     = frm;
endmodule

// File: tb/tb_formula_loader.sv
// Randomized bench for formula_loader with a list-based reference model and directed scenarios.
module tb_formula_loader;
  import formula_loader_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  bit   hold_off = 1'b0;

  formula_loader_if bus();

  formula_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Reference: rebuild the whole formula from the accepted beat list
  function automatic void build(input lit_beat q[$], output formula_t f, output logic e);
    int ci;
    int li;
    f  = '0;
    e  = 1'b0;
    ci = 0;
    li = 0;
    foreach (q[i]) begin
      if (!e) begin
        if (q[i].num == 0 || int'(q[i].num) > number_literal ||
            li == number_literal || ci == number_clauses) begin
          e = 1'b1;
        end else begin
          f.clauses[4'(ci)].lits[3'(li)].num = q[i].num;
          f.clauses[4'(ci)].lits[3'(li)].val = q[i].val;
          li++;
          if (q[i].lit_last || q[i].frm_last) begin
            f.clauses[4'(ci)].len = 3'(li);
            ci++;
            li = 0;
          end
        end
      end
    end
    f.len = e ? 4'd0 : 4'(ci);
  endfunction

  lit_beat  beats[$];
  logic     m_fresh   = 1'b1;
  logic     m_present = 1'b0;
  logic     m_err     = 1'b0;
  formula_t m_f       = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beats.delete();
      m_fresh   = 1'b1;
      m_present = 1'b0;
      m_err     = 1'b0;
      m_f       = '0;
    end else if (m_present) begin
      if (bus.formula_ready) begin
        m_present = 1'b0;
        beats.delete();
      end
    end else begin
      if (!m_fresh && bus.lit_valid) begin
        beats.push_back('{num: bus.lit_num, val: bus.lit_val,
                          lit_last: bus.lit_last, frm_last: bus.frm_last});
        if (bus.frm_last) begin
          build(beats, m_f, m_err);
          m_present = 1'b1;
        end
      end
      m_fresh = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_lit_ready", 256'(bus.lit_ready), 256'(0));
      chk("rst_formula_valid", 256'(bus.formula_valid), 256'(0));
      chk("rst_err", 256'(bus.err), 256'(0));
      chk("rst_formula", 256'(bus.formula_o), 256'(0));
    end else begin
      chk("lit_ready", 256'(bus.lit_ready), 256'(!m_fresh && !m_present));
      chk("formula_valid", 256'(bus.formula_valid), 256'(m_present));
      if (m_present) begin
        chk("err", 256'(bus.err), 256'(m_err));
        if (m_err) chk("err_len", 256'(bus.formula_o.len), 256'(0));
        else       chk("formula", 256'(bus.formula_o), 256'(m_f));
      end
    end
  end

  always @(posedge clk) begin
    #1;
    bus.formula_ready = hold_off ? 1'b0 : ($urandom_range(0, 2) != 0);
  end

  function automatic lit_beat mk(input int n, input bit v, input bit ll, input bit fl);
    return '{num: 3'(n), val: v, lit_last: ll, frm_last: fl};
  endfunction

  function automatic void gen(output lit_beat q[$]);
    int nc;
    int nl;
    q.delete();
    nc = ($urandom_range(0, 14) == 0) ? 11 : int'($urandom_range(1, 10));
    for (int c = 0; c < nc; c++) begin
      nl = ($urandom_range(0, 24) == 0) ? 6 : int'($urandom_range(1, 5));
      for (int l = 0; l < nl; l++) begin
        lit_beat b;
        b.num      = ($urandom_range(0, 39) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 5));
        b.val      = 1'($urandom_range(0, 1));
        b.lit_last = (l == nl - 1);
        b.frm_last = (c == nc - 1) && (l == nl - 1);
        q.push_back(b);
      end
    end
    if ($urandom_range(0, 3) == 0) q[q.size() - 1].lit_last = 1'b0;
  endfunction

  // Called and returns one time unit after a rising edge
  task automatic send(input lit_beat q[$], input int unsigned bubble_pct, output int unsigned cycles);
    bit acc;
    cycles = 0;
    foreach (q[i]) begin
      acc = 1'b0;
      while (!acc) begin
        if (bubble_pct != 0 && $urandom_range(0, 99) < bubble_pct) begin
          bus.lit_valid = 1'b0;
          bus.lit_num   = 3'($urandom_range(0, 7));
          bus.lit_val   = 1'($urandom_range(0, 1));
          bus.lit_last  = 1'($urandom_range(0, 1));
          bus.frm_last  = 1'($urandom_range(0, 1));
        end else begin
          bus.lit_valid = 1'b1;
          bus.lit_num   = q[i].num;
          bus.lit_val   = q[i].val;
          bus.lit_last  = q[i].lit_last;
          bus.frm_last  = q[i].frm_last;
        end
        @(negedge clk);
        acc = bus.lit_valid && bus.lit_ready;
        @(posedge clk);
        #1;
        cycles++;
        if (cycles > 3000) begin
          timeout("send");
          bus.lit_valid = 1'b0;
          return;
        end
      end
    end
    bus.lit_valid = 1'b0;
  endtask

  task automatic wait_valid(output int unsigned lat);
    lat = 0;
    forever begin
      @(negedge clk);
      if (bus.formula_valid) return;
      lat++;
      if (lat > 200) begin
        timeout("wait_valid");
        return;
      end
    end
  endtask

  task automatic wait_idle();
    int unsigned n;
    n = 0;
    forever begin
      @(negedge clk);
      if (!bus.formula_valid) break;
      n++;
      if (n > 200) begin
        timeout("wait_idle");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    lit_beat     q[$];
    int unsigned cyc;
    int unsigned lat;
    formula_t    snap;

    bus.lit_valid = 1'b0;
    bus.lit_num   = '0;
    bus.lit_val   = 1'b0;
    bus.lit_last  = 1'b0;
    bus.frm_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // single clause
    q = '{mk(1, 1, 0, 0), mk(3, 0, 0, 0), mk(5, 1, 1, 1)};
    send(q, 0, cyc);
    wait_valid(lat);
    chk("single_latency", 256'(lat), 256'(0));
    chk("single_len", 256'(bus.formula_o.len), 256'(1));
    chk("single_clen", 256'(bus.formula_o.clauses[0].len), 256'(3));
    chk("single_lit0", 256'(bus.formula_o.clauses[0].lits[0]), 256'(4'h3));
    chk("single_lit1", 256'(bus.formula_o.clauses[0].lits[1]), 256'(4'h6));
    chk("single_lit2", 256'(bus.formula_o.clauses[0].lits[2]), 256'(4'hB));
    chk("single_lit3", 256'(bus.formula_o.clauses[0].lits[3]), 256'(0));
    chk("single_lit4", 256'(bus.formula_o.clauses[0].lits[4]), 256'(0));
    chk("single_c1", 256'(bus.formula_o.clauses[1]), 256'(0));
    chk("single_err", 256'(bus.err), 256'(0));
    wait_idle();

    // full capacity, no bubbles
    q.delete();
    for (int c = 0; c < 10; c++)
      for (int l = 0; l < 5; l++)
        q.push_back(mk(l + 1, 1'(c + l), l == 4, (c == 9) && (l == 4)));
    send(q, 0, cyc);
    chk("full_beats_cycles", 256'(cyc), 256'(50));
    wait_valid(lat);
    chk("full_len", 256'(bus.formula_o.len), 256'(10));
    for (int c = 0; c < 10; c++)
      chk("full_clen", 256'(bus.formula_o.clauses[c].len), 256'(5));
    chk("full_err", 256'(bus.err), 256'(0));
    wait_idle();

    // clause overflow
    q = '{mk(1, 1, 0, 0), mk(2, 1, 0, 0), mk(3, 1, 0, 0), mk(4, 1, 0, 0),
          mk(5, 1, 0, 0), mk(1, 0, 0, 0), mk(2, 0, 0, 0), mk(3, 0, 1, 1)};
    send(q, 0, cyc);
    wait_valid(lat);
    chk("ovf_err", 256'(bus.err), 256'(1));
    chk("ovf_len", 256'(bus.formula_o.len), 256'(0));
    wait_idle();

    // illegal literal number
    q = '{mk(2, 1, 0, 0), mk(0, 1, 0, 0), mk(3, 0, 1, 0), mk(4, 1, 1, 1)};
    send(q, 20, cyc);
    wait_valid(lat);
    chk("illegal_err", 256'(bus.err), 256'(1));
    chk("illegal_len", 256'(bus.formula_o.len), 256'(0));
    wait_idle();

    // backpressure then residue-free second formula
    hold_off = 1'b1;
    q.delete();
    for (int c = 0; c < 4; c++)
      for (int l = 0; l < 3; l++)
        q.push_back(mk(int'($urandom_range(1, 5)), 1'($urandom_range(0, 1)), l == 2, (c == 3) && (l == 2)));
    send(q, 0, cyc);
    wait_valid(lat);
    snap = bus.formula_o;
    chk("bp_len", 256'(snap.len), 256'(4));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_stable", 256'(bus.formula_o), 256'(snap));
      chk("bp_lit_ready", 256'(bus.lit_ready), 256'(0));
      chk("bp_valid", 256'(bus.formula_valid), 256'(1));
    end
    hold_off = 1'b0;
    wait_idle();
    q = '{mk(2, 1, 0, 0), mk(4, 0, 1, 1)};
    send(q, 0, cyc);
    wait_valid(lat);
    chk("second_len", 256'(bus.formula_o.len), 256'(1));
    chk("second_clen", 256'(bus.formula_o.clauses[0].len), 256'(2));
    chk("second_lit2", 256'(bus.formula_o.clauses[0].lits[2]), 256'(0));
    chk("second_c1", 256'(bus.formula_o.clauses[1]), 256'(0));
    wait_idle();

    // reset mid-formula
    q = '{mk(1, 1, 0, 0), mk(2, 1, 1, 0), mk(3, 0, 0, 0)};
    send(q, 0, cyc);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_lit_ready", 256'(bus.lit_ready), 256'(0));
    chk("mid_rst_valid", 256'(bus.formula_valid), 256'(0));
    chk("mid_rst_err", 256'(bus.err), 256'(0));
    chk("mid_rst_formula", 256'(bus.formula_o), 256'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    q = '{mk(1, 1, 0, 0), mk(2, 0, 1, 0), mk(3, 1, 1, 1)};
    send(q, 0, cyc);
    wait_valid(lat);
    chk("post_rst_len", 256'(bus.formula_o.len), 256'(2));
    chk("post_rst_err", 256'(bus.err), 256'(0));
    wait_idle();

    // randomized formulas
    for (int unsigned k = 0; k < 40; k++) begin
      gen(q);
      send(q, 25, cyc);
      wait_valid(lat);
      wait_idle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
